jtbubl_romslot: RTL and testbench



---
 rtl/jtbubl_romslot.sv | 136 +++++++++++++
 tb/tb_jtbubl_romslot.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_romslot.sv
// rtl/jtbubl_romslot.sv - graphics ROM fetch responder with a 2-entry word cache
//
// Serves rom_cs/rom_addr requests from the video engine out of a two-entry
// tag cache of DW-bit words. A miss issues a single word request to the SDRAM
// controller, fills the least-recently-used entry and then serves it as a hit.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rom_cs, rom_addr    requester strobe and word address
//   rom_ok, rom_data    returned word, valid for the current rom_addr
//   sdram_req/addr      request to the SDRAM controller (16-bit-word address)
//   sdram_ack           controller accepted the request
//   data_rdy, data_read one-cycle data strobe and word from SDRAM

module jtbubl_romslot #(
    parameter int             AW     = 18,
    parameter int             DW     = 32,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = 22'h10000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic           rom_ok,
    output logic [DW-1:0]  rom_data,
    output logic           sdram_req,
    output logic [SDW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [DW-1:0]  data_read
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   tag0, tag1;
    logic [DW-1:0]   data0, data1;
    logic            valid0, valid1;
    logic            lru;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   fill_data;
    logic            ok_r;
    logic [AW-1:0]   last_addr;

    logic            hit0, hit1, hit;
    logic [SDW-1:0]  next_addr;

    always_comb begin
        hit0      = rom_cs & valid0 & (tag0 == rom_addr);
        hit1      = rom_cs & valid1 & (tag1 == rom_addr);
        hit       = hit0 | hit1;
        // Word address doubled into 16-bit units; wraps modulo 2^SDW.
        next_addr = OFFSET + SDW'({rom_addr, 1'b0});
    end

    // ok_r refers to the address seen last cycle; masking with the address
    // compare keeps rom_ok low during the cycle a new address is presented.
    assign rom_ok = rom_cs & ok_r & (rom_addr == last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag0       <= '0;
            tag1       <= '0;
            data0      <= '0;
            data1      <= '0;
            valid0     <= 1'b0;
            valid1     <= 1'b0;
            lru        <= 1'b0;
            req_addr   <= '0;
            fill_data  <= '0;
            ok_r       <= 1'b0;
            last_addr  <= '0;
            rom_data   <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            ok_r      <= hit;
            last_addr <= rom_addr;
            if (hit) begin
                rom_data <= hit0 ? data0 : data1;
                lru      <= hit0;
            end

            case (state)
                IDLE: begin
                    if (rom_cs && !hit) begin
                        req_addr   <= rom_addr;
                        sdram_addr <= next_addr;
                        sdram_req  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (data_rdy) begin
                            fill_data <= data_read;
                            state     <= FILL;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        fill_data <= data_read;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (lru) begin
                        tag1   <= req_addr;
                        data1  <= fill_data;
                        valid1 <= 1'b1;
                    end else begin
                        tag0   <= req_addr;
                        data0  <= fill_data;
                        valid0 <= 1'b1;
                    end
                    // Placed after the hit update so the new fill is MRU.
                    lru   <= ~lru;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtbubl_romslot.sv
// tb/tb_jtbubl_romslot.sv - directed self-checking bench for jtbubl_romslot

module tb_jtbubl_romslot;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    int n_cmp = 0;
    int n_bad = 0;

    jtbubl_romslot dut (
        .clk        (clk),
        .rst        (rst),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_ok     (rom_ok),
        .rom_data   (rom_data),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] sd_addr(input logic [17:0] a);
        logic [21:0] r;
        r = 22'h10000 + {3'b000, a, 1'b0};
        return r;
    endfunction

    // Present a missing address, ack next cycle, data the cycle after, then
    // expect the hit 3 edges after the data strobe.
    task automatic miss_fill(input string tag, input logic [17:0] a, input logic [31:0] d);
        rom_cs   = 1'b1;
        rom_addr = a;
        tick();
        check({tag, "_req"},  {63'd0, sdram_req}, 64'd1);
        check({tag, "_addr"}, {42'd0, sdram_addr}, {42'd0, sd_addr(a)});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
        data_read = 32'h0;
        tick();
        tick();
        #1;
        check({tag, "_ok"},   {63'd0, rom_ok}, 64'd1);
        check({tag, "_data"}, {32'd0, rom_data}, {32'd0, d});
    endtask

    // Switch straight to a different cached address: masked on the first
    // cycle, valid one cycle later, no SDRAM traffic.
    task automatic hit_check(input string tag, input logic [17:0] a, input logic [31:0] d);
        rom_cs   = 1'b1;
        rom_addr = a;
        #1;
        check({tag, "_mask"}, {63'd0, rom_ok}, 64'd0);
        tick();
        check({tag, "_ok"},   {63'd0, rom_ok}, 64'd1);
        check({tag, "_data"}, {32'd0, rom_data}, {32'd0, d});
        check({tag, "_noreq"}, {63'd0, sdram_req}, 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rom_cs    = 1'b0;
        rom_addr  = 18'h0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = 32'h0;
        tick();
        tick();
        check("rst_req",  {63'd0, sdram_req}, 64'd0);
        check("rst_addr", {42'd0, sdram_addr}, 64'd0);
        check("rst_ok",   {63'd0, rom_ok}, 64'd0);
        check("rst_data", {32'd0, rom_data}, 64'd0);
        rst = 1'b0;

        // First miss: ack next cycle, data 3 cycles after ack.
        rom_cs   = 1'b1;
        rom_addr = 18'h00010;
        #1;
        check("m1_miss_ok", {63'd0, rom_ok}, 64'd0);
        tick();
        check("m1_req",  {63'd0, sdram_req}, 64'd1);
        check("m1_addr", {42'd0, sdram_addr}, {42'd0, 22'h10020});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("m1_req_drop", {63'd0, sdram_req}, 64'd0);
        tick();
        tick();
        data_rdy  = 1'b1;
        data_read = 32'hDEADBEEF;
        tick();
        data_rdy  = 1'b0;
        data_read = 32'h0;
        check("m1_ok_fill", {63'd0, rom_ok}, 64'd0);
        tick();
        check("m1_ok_pre", {63'd0, rom_ok}, 64'd0);
        tick();
        check("m1_ok",    {63'd0, rom_ok}, 64'd1);
        check("m1_data",  {32'd0, rom_data}, {32'd0, 32'hDEADBEEF});
        check("m1_noreq", {63'd0, sdram_req}, 64'd0);

        // Repeat after a gap: hit 1 cycle after rom_cs.
        rom_cs = 1'b0;
        tick();
        tick();
        check("gap_ok", {63'd0, rom_ok}, 64'd0);
        rom_cs = 1'b1;
        #1;
        check("rh_ok0", {63'd0, rom_ok}, 64'd0);
        tick();
        check("rh_ok1",  {63'd0, rom_ok}, 64'd1);
        check("rh_data", {32'd0, rom_data}, {32'd0, 32'hDEADBEEF});
        check("rh_noreq", {63'd0, sdram_req}, 64'd0);

        // LRU replacement.
        miss_fill("f1", 18'h1, 32'h11111111);
        miss_fill("f2", 18'h2, 32'h22222222);
        hit_check("h1a", 18'h1, 32'h11111111);
        miss_fill("f3", 18'h3, 32'h33333333);
        hit_check("h1b", 18'h1, 32'h11111111);
        hit_check("h3",  18'h3, 32'h33333333);
        miss_fill("f2b", 18'h2, 32'h22222222);

        // Address changes while waiting for data.
        rom_cs   = 1'b1;
        rom_addr = 18'h5;
        tick();
        check("ch_req",  {63'd0, sdram_req}, 64'd1);
        check("ch_addr", {42'd0, sdram_addr}, {42'd0, 22'h1000A});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rom_addr  = 18'h6;
        tick();
        check("ch_ok_w",  {63'd0, rom_ok}, 64'd0);
        check("ch_busy",  {63'd0, sdram_req}, 64'd0);
        data_rdy  = 1'b1;
        data_read = 32'h55555555;
        tick();
        data_rdy  = 1'b0;
        data_read = 32'h0;
        tick();
        check("ch_ok_f", {63'd0, rom_ok}, 64'd0);
        tick();
        check("ch_req2",  {63'd0, sdram_req}, 64'd1);
        check("ch_addr2", {42'd0, sdram_addr}, {42'd0, 22'h1000C});
        check("ch_ok_r",  {63'd0, rom_ok}, 64'd0);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = 32'h66666666;
        tick();
        data_rdy  = 1'b0;
        data_read = 32'h0;
        tick();
        tick();
        check("ch6_ok",   {63'd0, rom_ok}, 64'd1);
        check("ch6_data", {32'd0, rom_data}, {32'd0, 32'h66666666});
        hit_check("h5", 18'h5, 32'h55555555);

        // Ack and data in the same cycle.
        rom_addr = 18'h7;
        tick();
        check("sc_req", {63'd0, sdram_req}, 64'd1);
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'h12345678;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = 32'h0;
        check("sc_req_drop", {63'd0, sdram_req}, 64'd0);
        tick();
        check("sc_ok0", {63'd0, rom_ok}, 64'd0);
        tick();
        check("sc_ok1",  {63'd0, rom_ok}, 64'd1);
        check("sc_data", {32'd0, rom_data}, {32'd0, 32'h12345678});

        // Reset during WAIT, then a late data strobe.
        rom_addr = 18'h8;
        tick();
        check("rw_req", {63'd0, sdram_req}, 64'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rom_cs    = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_req0",  {63'd0, sdram_req}, 64'd0);
        check("rw_ok0",   {63'd0, rom_ok}, 64'd0);
        check("rw_data0", {32'd0, rom_data}, 64'd0);
        data_rdy  = 1'b1;
        data_read = 32'hBADBAD00;
        tick();
        data_rdy  = 1'b0;
        data_read = 32'h0;
        tick();
        check("rw_late_req", {63'd0, sdram_req}, 64'd0);
        check("rw_late_ok",  {63'd0, rom_ok}, 64'd0);
        miss_fill("rw_new", 18'h8, 32'h88888888);
        // Entry for 18'h7 was invalidated by the reset.
        rom_addr = 18'h7;
        tick();
        check("rw_inv7", {63'd0, sdram_req}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
